// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types, code points and helpers for the data-memory access controller.
// State codes, access-size codes, load lane/extension select codes and store lane helpers.
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } state_e;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    localparam logic [2:0] SelByte0 = 3'b000;
    localparam logic [2:0] SelByte1 = 3'b001;
    localparam logic [2:0] SelByte2 = 3'b010;
    localparam logic [2:0] SelByte3 = 3'b011;
    localparam logic [2:0] SelHalf0 = 3'b100;
    localparam logic [2:0] SelHalf1 = 3'b101;
    localparam logic [2:0] SelWord  = 3'b110;

    // Bit position of the sign flag within the 4-bit {sign, select} code.
    localparam int unsigned SignBit = 3;

    // The illegal size code 2'b11 falls through to word handling everywhere below.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SizeByte: is_aligned = 1'b1;
            SizeHalf: is_aligned = ~a[0];
            default:  is_aligned = (a == 2'b00);
        endcase
    endfunction

    function automatic logic [2:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SizeByte: lane_sel = {1'b0, a};
            SizeHalf: lane_sel = a[1] ? SelHalf1 : SelHalf0;
            default:  lane_sel = SelWord;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SizeByte: store_strb = 4'b0001 << a;
            SizeHalf: store_strb = a[1] ? 4'b1100 : 4'b0011;
            default:  store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SizeByte: store_data = {4{wd[7:0]}};
            SizeHalf: store_data = {2{wd[15:0]}};
            default:  store_data = wd;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_lane_ext.sv
// Load result formatter: picks the addressed byte/half lane of a bus word and
// sign- or zero-extends it to 32 bits; the word select passes data through.
module load_lane_ext
    import dmem_access_ctrl_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] data_o
);

    logic sgn;
    assign sgn = sel_i[SignBit];

    always_comb begin
        data_o = data_i;
        case (sel_i[2:0])
            SelByte0: data_o = {{24{sgn & data_i[7]}},  data_i[7:0]};
            SelByte1: data_o = {{24{sgn & data_i[15]}}, data_i[15:8]};
            SelByte2: data_o = {{24{sgn & data_i[23]}}, data_i[23:16]};
            SelByte3: data_o = {{24{sgn & data_i[31]}}, data_i[31:24]};
            SelHalf0: data_o = {{16{sgn & data_i[15]}}, data_i[15:0]};
            SelHalf1: data_o = {{16{sgn & data_i[31]}}, data_i[31:16]};
            default:  data_o = data_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: alignment check, single bus transaction
// per request with pipeline stall, flush-kill of in-flight loads/stores, address errors.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_e      state_q;
    logic        kill_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        adel_q;
    logic        ades_q;
    logic [31:0] badvaddr_q;
    logic [31:0] load_ext;
    logic        in_bus;
    logic        bus_store;

    load_lane_ext u_load_lane_ext (
        .data_i (mem_rdata),
        .sel_i  ({sign_q, lane_sel(size_q, addr_q[1:0])}),
        .data_o (load_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            kill_q     <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            badvaddr_q <= '0;
        end else begin
            done_q <= 1'b0;
            adel_q <= 1'b0;
            ades_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req && !flush) begin
                        we_q    <= we;
                        size_q  <= size;
                        sign_q  <= sign;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (is_aligned(size, addr[1:0])) begin
                            state_q <= StBus;
                        end else begin
                            state_q    <= StErr;
                            adel_q     <= ~we;
                            ades_q     <= we;
                            badvaddr_q <= addr;
                        end
                    end
                end
                StBus: begin
                    // The bus beat always runs to completion; a flush only suppresses done.
                    if (mem_ack) begin
                        kill_q <= 1'b0;
                        if (kill_q || flush) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            rdata_q <= we_q ? 32'h0 : load_ext;
                        end
                    end else if (flush) begin
                        kill_q <= 1'b1;
                    end
                end
                StDone:  state_q <= StIdle;
                StErr:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_bus    = (state_q == StBus);
    assign bus_store = in_bus & we_q;

    assign mem_req   = in_bus;
    assign mem_we    = bus_store;
    assign mem_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wstrb = bus_store ? store_strb(size_q, addr_q[1:0]) : 4'b0000;
    assign mem_wdata = bus_store ? store_data(size_q, wdata_q) : 32'h0;

    // Gated by rst_n so the pipeline is released the moment reset asserts.
    assign stall = rst_n & (((state_q == StIdle) & req & ~flush) | in_bus | (state_q == StErr));

    assign done     = done_q;
    assign rdata    = rdata_q;
    assign adel     = adel_q;
    assign ades     = ades_q;
    assign badvaddr = badvaddr_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, table-driven bench for dmem_access_ctrl plus hand-written flush and
// reset sequences.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, sign, flush;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        stall, done, adel, ades;
    logic [31:0] rdata, badvaddr;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        int          waits;
        logic        err;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    dmem_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign      (sign),
        .addr      (addr),
        .wdata     (wdata),
        .flush     (flush),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .adel      (adel),
        .ades      (ades),
        .badvaddr  (badvaddr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic run_vec(input vec_t v, input string tag);
        int stall_cycles;
        stall_cycles = 0;
        req = 1'b1; we = v.we; size = v.size; sign = v.sign; addr = v.addr; wdata = v.wdata;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        #1;
        check($sformatf("%s.req_stall", tag), {31'b0, stall}, 32'd1);
        stall_cycles += stall;
        @(posedge clk); #1;
        if (v.err) begin
            check($sformatf("%s.adel", tag), {31'b0, adel}, {31'b0, ~v.we});
            check($sformatf("%s.ades", tag), {31'b0, ades}, {31'b0, v.we});
            check($sformatf("%s.badvaddr", tag), badvaddr, v.addr);
            check($sformatf("%s.err_mem_req", tag), {31'b0, mem_req}, 32'd0);
            check($sformatf("%s.err_stall", tag), {31'b0, stall}, 32'd1);
            req = 1'b0;
            @(posedge clk); #1;
            check($sformatf("%s.err_pulse_end", tag), {30'b0, adel, ades}, 32'd0);
            check($sformatf("%s.err_idle_stall", tag), {31'b0, stall}, 32'd0);
        end else begin
            check($sformatf("%s.mem_req", tag), {31'b0, mem_req}, 32'd1);
            check($sformatf("%s.mem_addr", tag), mem_addr, v.exp_maddr);
            check($sformatf("%s.mem_we", tag), {31'b0, mem_we}, {31'b0, v.we});
            check($sformatf("%s.mem_wstrb", tag), {28'b0, mem_wstrb}, {28'b0, v.exp_strb});
            if (v.we) check($sformatf("%s.mem_wdata", tag), mem_wdata, v.exp_mwdata);
            stall_cycles += stall;
            for (int i = 0; i < v.waits; i++) begin
                @(posedge clk); #1;
                check($sformatf("%s.wait_done", tag), {31'b0, done}, 32'd0);
                stall_cycles += stall;
            end
            mem_ack = 1'b1; mem_rdata = v.bus_rdata;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 32'h0;
            check($sformatf("%s.done", tag), {31'b0, done}, 32'd1);
            check($sformatf("%s.rdata", tag), rdata, v.exp_rdata);
            check($sformatf("%s.done_stall", tag), {31'b0, stall}, 32'd0);
            check($sformatf("%s.done_mem_req", tag), {31'b0, mem_req}, 32'd0);
            check($sformatf("%s.stall_cycles", tag), stall_cycles, v.waits + 2);
            req = 1'b0;
            @(posedge clk); #1;
            check($sformatf("%s.done_pulse_end", tag), {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        //          we    size   sgn  addr          wdata         bus_rdata    w  err maddr         strb     mwdata        rdata
        vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h8011_2233, 2, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0,        32'hBEEF_1234, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_BEEF};
        vecs[2]  = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        1, 1'b0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0,        32'h0,         0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 2'b10, 1'b0, 32'h0000_3002, 32'h1234_5678, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h1234_56A5, 32'h0,        0, 1'b0, 32'h0000_5000, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h0000_5002, 32'h0,        32'h11F2_3344, 1, 1'b0, 32'h0000_5000, 4'b0000, 32'h0,        32'h0000_00F2};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_6000, 32'h0,        32'h1234_8001, 0, 1'b0, 32'h0000_6000, 4'b0000, 32'h0,        32'hFFFF_8001};
        vecs[8]  = '{1'b0, 2'b10, 1'b1, 32'h0000_7004, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'h0000_7004, 4'b0000, 32'h0,        32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 2'b11, 1'b1, 32'h0000_7008, 32'h0,        32'hCAFE_F00D, 0, 1'b0, 32'h0000_7008, 4'b0000, 32'h0,        32'hCAFE_F00D};
        vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_700A, 32'h0,        32'h0,         0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h0000_8000, 32'h0102_0304, 32'h0,        0, 1'b0, 32'h0000_8000, 4'b1111, 32'h0102_0304, 32'h0};
        vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h0000_6001, 32'h0,        32'h0,         0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b1, 2'b00, 1'b0, 32'h0000_9003, 32'h0000_005A, 32'h0,        0, 1'b0, 32'h0000_9000, 4'b1000, 32'h5A5A_5A5A, 32'h0};

        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign = 1'b0; flush = 1'b0;
        addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        #12;
        check("reset.stall", {31'b0, stall}, 32'd0);
        check("reset.done", {31'b0, done}, 32'd0);
        check("reset.mem_req", {31'b0, mem_req}, 32'd0);
        check("reset.rdata", rdata, 32'h0);
        check("reset.badvaddr", badvaddr, 32'h0);
        check("reset.err", {30'b0, adel, ades}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Flush with req in IDLE: no stall, nothing starts.
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0000_4000; flush = 1'b1;
        #1;
        check("idle_flush.stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        check("idle_flush.mem_req", {31'b0, mem_req}, 32'd0);
        req = 1'b0; flush = 1'b0;

        // Stray ack in IDLE is ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("stray_ack.done", {31'b0, done}, 32'd0);
        check("stray_ack.mem_req", {31'b0, mem_req}, 32'd0);

        // Flush during BUS: transaction completes on the bus but done never fires.
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0000_4000;
        @(posedge clk); #1;
        check("kill.bus", {31'b0, mem_req}, 32'd1);
        flush = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        check("kill.not_aborted", {31'b0, mem_req}, 32'd1);
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("kill.no_done", {31'b0, done}, 32'd0);
        check("kill.idle_mem_req", {31'b0, mem_req}, 32'd0);
        check("kill.idle_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        check("kill.no_late_done", {31'b0, done}, 32'd0);
        run_vec(vecs[8], "after_kill");

        // Reset mid-BUS: outputs drop asynchronously, late ack ignored.
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h0000_4000; wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        check("rst_bus.mem_req", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_bus.mem_req_drop", {31'b0, mem_req}, 32'd0);
        check("rst_bus.stall_drop", {31'b0, stall}, 32'd0);
        check("rst_bus.mem_we_drop", {31'b0, mem_we}, 32'd0);
        req = 1'b0; mem_ack = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("rst_bus.late_ack_done", {31'b0, done}, 32'd0);
        check("rst_bus.late_ack_mem_req", {31'b0, mem_req}, 32'd0);
        run_vec(vecs[1], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port req  input  1  MEM-stage access valid; held stable with its operands while stall=1.
REQ-004 SHALL have port we  input  1  1=store, 0=load.
REQ-005 SHALL have port size  input  2  00 byte, 01 half, 10 word; 11 illegal, treated as word.
REQ-006 SHALL have port sign  input  1  load extension: 1 sign, 0 zero; ignored for word and stores.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  store data, right-justified.
REQ-009 SHALL have port flush  input  1  pipeline kill (exception/interrupt).
REQ-010 SHALL have ports stall output 1, done output 1, rdata output 32: pipeline hold, one-cycle completion pulse, extended load result.
REQ-011 SHALL have ports adel output 1, ades output 1, badvaddr output 32: load/store address-error pulse, faulting address.
REQ-012 SHALL have memory ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wstrb out 4, mem_wdata out 32, mem_rdata in 32, mem_ack in 1.

Function
REQ-013 SHALL implement FSM IDLE, BUS, DONE, ERR.
REQ-014 Alignment: half needs addr[0]=0, word needs addr[1:0]=00; byte always aligned.
REQ-015 IDLE: req & !flush & aligned -> BUS, latching we/size/sign/addr/wdata; req & !flush & misaligned -> ERR; otherwise stay.
REQ-016 BUS: mem_req=1, operands from latches, mem_addr={addr[31:2],2'b00}; remain until mem_ack=1.
REQ-017 BUS with mem_ack: -> DONE, capture extended rdata; if kill flag set, -> IDLE with no done.
REQ-018 flush during BUS SHALL set a kill flag; bus transaction is never aborted; kill flag clears on leaving BUS.
REQ-019 DONE: done=1 for exactly one cycle, rdata valid (0 for stores), -> IDLE.
REQ-020 ERR: adel=!we or ades=we for exactly one cycle, badvaddr=latched addr, no mem_req, -> IDLE.
REQ-021 stall SHALL equal (IDLE & req & !flush) | BUS | ERR (combinational); stall=0 in DONE.
REQ-022 Store strobes: byte 4'b0001<<addr[1:0]; half addr[1]?1100:0011; word 1111; loads 0000.
REQ-023 Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-024 Load lane select: byte lane addr[1:0], half lane addr[1]; extension to 32 bits per sign; word passes mem_rdata.
REQ-025 Minimum latency: request cycle 0, BUS from cycle 1, done one cycle after mem_ack sampled.
REQ-026 mem_ack outside BUS SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL force IDLE, kill flag 0, all outputs and latches 0, including mid-BUS (mem_req drops immediately).
REQ-028 After rst_n rises, first accepted req no earlier than first rising edge with rst_n=1.

Structure
REQ-029 Shared define file SHALL hold FSM state codes, size codes (BYTE/HALF/WORD), and lane/extension select codes BYTE0..BYTE3=000..011, HALF0=100, HALF1=101, WORD=110, plus sign flag bit.
REQ-030 Lane select + extension SHALL be sub-module load_lane_ext (inputs 32-bit data, 4-bit {sign,select}; output 32-bit); remaining logic in dmem_access_ctrl.

Verification
REQ-031 lb sign=1 addr=0x1003, mem_rdata=0x80112233, ack after 2 wait cycles -> rdata=0xFFFFFF80, done one cycle after ack, stall high 4 cycles.
REQ-032 lhu addr=0x1002, mem_rdata=0xBEEF1234 -> rdata=0x0000BEEF; mem_addr=0x1000.
REQ-033 sh addr=0x2002 wdata=0x0000ABCD -> mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1, done then rdata=0.
REQ-034 lw addr=0x3001 -> adel pulse 1 cycle, badvaddr=0x3001, no mem_req; sw addr=0x3002 -> ades pulse.
REQ-035 lw addr=0x4000, flush in BUS, ack 3 cycles later -> no done, return IDLE, next request accepted normally.
REQ-036 rst_n low mid-BUS -> mem_req, stall 0 asynchronously; late mem_ack ignored.
